// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C target receiver.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StData,
      StDataAck,
      StIgnore
   } i2c_state_e;

   localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus counting glitch filter for one open-drain I2C line.
// Emits the filtered level and one-cycle rise/fall pulses aligned to level changes.
module i2c_line_filter #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [3:0] CntLast = 4'(FILT_LEN - 1);

   logic       sync1_q, sync2_q;
   logic       level_q, level_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;
   logic [3:0] cnt_q, cnt_d;

   // Any sample equal to the current level restarts the run count.
   always_comb begin
      level_d = level_q;
      cnt_d   = 4'd0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= 4'd0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= line_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: detects START/STOP, matches a 7-bit address, ACKs bytes
// and presents each accepted data byte as a one-cycle rx_valid pulse.
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0]  ADDR     = 7'h28,
   parameter int unsigned FILT_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       start_det,
   output logic       stop_det,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_in (scl_in),
      .level   (scl_lvl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_in (sda_in),
      .level   (sda_lvl),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   i2c_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       first_q, first_d;
   logic       ack_phase_q, ack_phase_d;
   logic       sda_oe_q, sda_oe_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_first_q, rx_first_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       busy_q, busy_d;

   logic [7:0] byte_in;
   logic       addr_match;

   assign byte_in    = {shift_q[6:0], sda_lvl};
   assign addr_match = (byte_in[7:1] == ADDR) && (byte_in[0] == I2C_WRITE);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      first_d     = first_q;
      ack_phase_d = ack_phase_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      rx_valid_d  = 1'b0;
      rx_first_d  = 1'b0;
      start_d     = 1'b0;
      stop_d      = 1'b0;

      // START/STOP outrank any coincident scl edge.
      if (scl_lvl && sda_fall) begin
         start_d     = 1'b1;
         busy_d      = 1'b1;
         bit_cnt_d   = 3'd0;
         ack_phase_d = 1'b0;
         sda_oe_d    = 1'b0;
         state_d     = StAddr;
      end else if (scl_lvl && sda_rise) begin
         stop_d   = 1'b1;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
         state_d  = StIdle;
      end else begin
         unique case (state_q)
            StAddr, StData: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ack_phase_d = 1'b0;
                     if (state_q == StData)  state_d = StDataAck;
                     else if (addr_match)    state_d = StAddrAck;
                     else                    state_d = StIgnore;
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     sda_oe_d    = 1'b1;
                  end else begin
                     ack_phase_d = 1'b0;
                     sda_oe_d    = 1'b0;
                     first_d     = 1'b1;
                     bit_cnt_d   = 3'd0;
                     state_d     = StData;
                  end
               end
            end
            StDataAck: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     if (rx_ready) begin
                        sda_oe_d   = 1'b1;
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                     end
                  end else begin
                     // sda_oe_q still records whether this byte was ACKed.
                     ack_phase_d = 1'b0;
                     sda_oe_d    = 1'b0;
                     bit_cnt_d   = 3'd0;
                     state_d     = sda_oe_q ? StData : StIgnore;
                  end
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         rx_data_q   <= 8'd0;
         first_q     <= 1'b0;
         ack_phase_q <= 1'b0;
         sda_oe_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_first_q  <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         first_q     <= first_d;
         ack_phase_q <= ack_phase_d;
         sda_oe_q    <= sda_oe_d;
         rx_valid_q  <= rx_valid_d;
         rx_first_q  <= rx_first_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         busy_q      <= busy_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_first  = rx_first_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench: bit-bangs I2C writes into i2c_target_rx over a wired-AND SDA line.
module tb_i2c_target_rx;

   localparam int Q = 16;  // quarter bit period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       rx_ready = 1'b1;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_first, start_det, stop_det, busy;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_rx #(.ADDR(7'h28), .FILT_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_first  (rx_first),
      .start_det (start_det),
      .stop_det  (stop_det),
      .busy      (busy)
   );

   always #10 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Event monitor; the sequence below only reads these counters.
   int         n_valid = 0, n_start = 0, n_stop = 0, n_oe = 0;
   logic [7:0] log_data  [0:63];
   logic       log_first [0:63];

   always @(negedge clk) begin
      if (rx_valid && n_valid < 64) begin
         log_data[n_valid]  = rx_data;
         log_first[n_valid] = rx_first;
      end
      if (rx_valid)  n_valid++;
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (sda_oe)    n_oe++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(Q);
      sda_m = 1'b0; wait_cyc(Q);
      scl_m = 1'b0; wait_cyc(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(Q);
      sda_m = 1'b1; wait_cyc(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         sda_m = b[i]; wait_cyc(Q);
         scl_m = 1'b1; wait_cyc(2 * Q);
         scl_m = 1'b0; wait_cyc(Q);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(Q);
      ack = ~sda_line;
      wait_cyc(Q);
      scl_m = 1'b0; wait_cyc(Q);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ack;
      int   bv, bs, bp, bo;

      // Reset state
      wait_cyc(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_start_det", start_det, 0);
      check("rst_stop_det", stop_det, 0);
      rst_n = 1'b1;
      wait_cyc(Q);

      // Clear command 0x50 0xFE 0x51
      bv = n_valid; bs = n_start; bp = n_stop;
      i2c_start();
      check("clr_busy_mid", busy, 1);
      send_byte(8'h50, ack); check("clr_ack_addr", ack, 1);
      send_byte(8'hFE, ack); check("clr_ack_fe", ack, 1);
      send_byte(8'h51, ack); check("clr_ack_51", ack, 1);
      i2c_stop();
      wait_cyc(Q);
      check("clr_nvalid", n_valid - bv, 2);
      check("clr_byte0", log_data[bv], 8'hFE);
      check("clr_first0", log_first[bv], 1);
      check("clr_byte1", log_data[bv + 1], 8'h51);
      check("clr_first1", log_first[bv + 1], 0);
      check("clr_nstart", n_start - bs, 1);
      check("clr_nstop", n_stop - bp, 1);
      check("clr_busy_end", busy, 0);
      check("clr_rx_data_hold", rx_data, 8'h51);

      // Wrong address
      bv = n_valid; bo = n_oe;
      i2c_start();
      send_byte(8'h52, ack); check("wa_nack_addr", ack, 0);
      send_byte(8'hAA, ack); check("wa_nack_data", ack, 0);
      i2c_stop();
      check("wa_oe_cycles", n_oe - bo, 0);
      check("wa_nvalid", n_valid - bv, 0);

      // Read bit set
      bv = n_valid;
      i2c_start();
      send_byte(8'h51, ack); check("rd_nack_addr", ack, 0);
      send_byte(8'h00, ack); check("rd_nack_data", ack, 0);
      i2c_stop();
      check("rd_nvalid", n_valid - bv, 0);

      // Backpressure
      bv = n_valid;
      i2c_start();
      send_byte(8'h50, ack); check("bp_ack_addr", ack, 1);
      send_byte(8'h41, ack); check("bp_ack_41", ack, 1);
      rx_ready = 1'b0;
      send_byte(8'h42, ack); check("bp_nack_42", ack, 0);
      rx_ready = 1'b1;
      send_byte(8'h43, ack); check("bp_nack_43", ack, 0);
      i2c_stop();
      check("bp_nvalid", n_valid - bv, 1);
      check("bp_byte", log_data[bv], 8'h41);
      check("bp_first", log_first[bv], 1);

      // 2-cycle SDA glitch with scl high
      bs = n_start; bp = n_stop;
      wait_cyc(Q);
      sda_m = 1'b0; wait_cyc(2);
      sda_m = 1'b1; wait_cyc(Q);
      check("gl_nstart", n_start - bs, 0);
      check("gl_nstop", n_stop - bp, 0);
      check("gl_busy", busy, 0);

      // Repeated START
      bv = n_valid; bs = n_start;
      i2c_start();
      send_byte(8'h50, ack); check("rs_ack_addr0", ack, 1);
      send_byte(8'h33, ack); check("rs_ack_33", ack, 1);
      i2c_start();
      send_byte(8'h50, ack); check("rs_ack_addr1", ack, 1);
      send_byte(8'h77, ack); check("rs_ack_77", ack, 1);
      i2c_stop();
      check("rs_nstart", n_start - bs, 2);
      check("rs_nvalid", n_valid - bv, 2);
      check("rs_byte0", log_data[bv], 8'h33);
      check("rs_first0", log_first[bv], 1);
      check("rs_byte1", log_data[bv + 1], 8'h77);
      check("rs_first1", log_first[bv + 1], 1);

      // STOP after 4 data bits
      bv = n_valid; bp = n_stop;
      i2c_start();
      send_byte(8'h50, ack); check("sp_ack_addr", ack, 1);
      send_bits(8'hC5, 4);
      i2c_stop();
      wait_cyc(Q);
      check("sp_nvalid", n_valid - bv, 0);
      check("sp_nstop", n_stop - bp, 1);
      check("sp_busy", busy, 0);

      // Reset while the address ACK is driven
      i2c_start();
      send_bits(8'h50, 8);
      begin
         int k;
         k = 0;
         while (!sda_oe && k < 4 * Q) begin
            wait_cyc(1);
            k++;
         end
         check("ra_oe_seen", sda_oe, 1);
      end
      rst_n = 1'b0;
      wait_cyc(1);
      check("ra_sda_oe", sda_oe, 0);
      check("ra_busy", busy, 0);
      check("ra_rx_data", rx_data, 0);
      check("ra_rx_valid", rx_valid, 0);
      check("ra_rx_first", rx_first, 0);
      check("ra_start_det", start_det, 0);
      check("ra_stop_det", stop_det, 0);
      scl_m = 1'b1; wait_cyc(Q);
      sda_m = 1'b1; wait_cyc(Q);
      rst_n = 1'b1;
      wait_cyc(Q);
      bv = n_valid;
      i2c_start();
      send_byte(8'h50, ack); check("ra_ack_addr", ack, 1);
      send_byte(8'h5A, ack); check("ra_ack_5a", ack, 1);
      i2c_stop();
      check("ra_nvalid", n_valid - bv, 1);
      check("ra_byte", log_data[bv], 8'h5A);
      check("ra_first", log_first[bv], 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
